// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit holding the HI/LO pair
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign-fixed in a final FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_res_q, neg_res_d, neg_a_q, neg_a_d, done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag, div_diff;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] product, prod_fix;

  always_comb begin
    a_mag     = (!op[0] && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    b_mag     = (!op[0] && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_q, q_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    // Only used when div_ge holds, so the result is below b_q and fits in WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    product   = {acc_q, q_q};
    prod_fix  = neg_res_q ? -product : product;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          neg_res_d = !op[0] && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          neg_a_d   = !op[0] && rs_data[WIDTH-1];
          acc_d     = '0;
          cnt_d     = '0;
          b_d       = b_mag;
          // Divide keeps raw rs_data in a_q so divide-by-zero can return it untouched.
          if (op[1]) begin
            q_d = a_mag;
            a_d = rs_data;
          end else begin
            q_d = b_mag;
            a_d = a_mag;
          end
          state_d = RUN;
        end else begin
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      RUN: begin
        if (op_q[1]) begin
          acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[1]) begin
          if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            lo_d = neg_res_q ? -q_q : q_q;
            hi_d = neg_a_q ? -acc_q : acc_q;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
